// File: rtl/iserdes_aligner.sv
// Word-alignment controller for multi-lane source-synchronous LVDS capture.
// Drives bitslip and IDELAY taps until the frame lane is stable, then forwards lane data.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | letting ISERDES/IDELAY settle after a slip or tap change
// CHECK  | comparing the frame lane against FRAME_PATTERN
// SLIP   | single bitslip pulse
// TAP    | TAP_STEP consecutive id_inc pulses
// LOCKED | aligned; forwarding data and watching for frame loss
// FAIL   | every slip/tap combination tried without success
module iserdes_aligner #(
  parameter int            N_LANES       = 4,
  parameter int            DW            = 8,
  parameter logic [DW-1:0] FRAME_PATTERN = 8'hF0,
  parameter int            SETTLE_CYCLES = 8,
  parameter int            MATCH_COUNT   = 16,
  parameter int            LOSS_COUNT    = 4,
  parameter int            TAP_STEP      = 2,
  localparam int           SW            = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [DW-1:0]         frame_in,
  input  logic [N_LANES*DW-1:0] data_in,
  output logic                  bitslip,
  output logic                  id_inc,
  output logic                  id_ld,
  output logic [N_LANES*DW-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  fail,
  output logic [SW-1:0]         slip_count,
  output logic [4:0]            tap_count,
  output logic [7:0]            loss_events
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_TAP, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [7:0]    SETTLE_L = 8'(SETTLE_CYCLES);
  localparam logic [7:0]    MATCH_L  = 8'(MATCH_COUNT);
  localparam logic [7:0]    LOSS_L   = 8'(LOSS_COUNT);
  localparam logic [4:0]    PHASE_L  = 5'(TAP_STEP - 1);
  localparam logic [5:0]    STEP_L   = 6'(TAP_STEP);
  localparam logic [SW-1:0] SLIP_MAX = SW'(DW - 1);

  state_t                  r_state;
  logic [7:0]              r_settle_cnt;
  logic [7:0]              r_match_cnt;
  logic [7:0]              r_loss_cnt;
  logic [4:0]              r_tap_phase;
  logic [SW-1:0]           r_slip_cnt;
  logic [4:0]              r_tap_cnt;
  logic [7:0]              r_loss_events;
  logic                    r_id_ld;
  logic [N_LANES*DW-1:0]   r_data_out;

  state_t                  w_state_nxt;
  logic [7:0]              w_settle_nxt;
  logic [7:0]              w_match_nxt;
  logic [7:0]              w_loss_nxt;
  logic [4:0]              w_phase_nxt;
  logic [SW-1:0]           w_slip_nxt;
  logic [4:0]              w_tap_nxt;
  logic [7:0]              w_loss_ev_nxt;
  logic                    w_id_ld_nxt;
  logic                    w_frame_ok;

  assign w_frame_ok = (frame_in == FRAME_PATTERN);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle_cnt;
    w_match_nxt   = r_match_cnt;
    w_loss_nxt    = r_loss_cnt;
    w_phase_nxt   = r_tap_phase;
    w_slip_nxt    = r_slip_cnt;
    w_tap_nxt     = r_tap_cnt;
    w_loss_ev_nxt = r_loss_events;
    w_id_ld_nxt   = 1'b0;
    if (start) begin
      w_id_ld_nxt  = 1'b1;
      w_slip_nxt   = '0;
      w_tap_nxt    = '0;
      w_match_nxt  = '0;
      w_loss_nxt   = '0;
      w_settle_nxt = SETTLE_L;
      w_state_nxt  = S_SETTLE;
    end else begin
      unique case (r_state)
        S_SETTLE: begin
          if (r_settle_cnt <= 8'd1) begin
            w_settle_nxt = '0;
            w_state_nxt  = S_CHECK;
          end else begin
            w_settle_nxt = r_settle_cnt - 8'd1;
          end
        end
        S_CHECK: begin
          if (w_frame_ok) begin
            if (r_match_cnt + 8'd1 == MATCH_L) begin
              w_match_nxt = '0;
              w_loss_nxt  = '0;
              w_state_nxt = S_LOCKED;
            end else begin
              w_match_nxt = r_match_cnt + 8'd1;
            end
          end else begin
            w_match_nxt = '0;
            if (r_slip_cnt < SLIP_MAX) begin
              w_state_nxt = S_SLIP;
            end else if (({1'b0, r_tap_cnt} + STEP_L) <= 6'd31) begin
              w_slip_nxt  = '0;
              w_phase_nxt = '0;
              w_state_nxt = S_TAP;
            end else begin
              w_state_nxt = S_FAIL;
            end
          end
        end
        S_SLIP: begin
          w_slip_nxt   = r_slip_cnt + 1'b1;
          w_settle_nxt = SETTLE_L;
          w_state_nxt  = S_SETTLE;
        end
        S_TAP: begin
          w_tap_nxt = r_tap_cnt + 5'd1;
          if (r_tap_phase == PHASE_L) begin
            w_settle_nxt = SETTLE_L;
            w_state_nxt  = S_SETTLE;
          end else begin
            w_phase_nxt = r_tap_phase + 5'd1;
          end
        end
        S_LOCKED: begin
          if (w_frame_ok) begin
            w_loss_nxt = '0;
          end else if (r_loss_cnt + 8'd1 == LOSS_L) begin
            // tap position survives a loss; the slip search restarts from zero
            w_loss_nxt    = '0;
            w_match_nxt   = '0;
            w_slip_nxt    = '0;
            w_settle_nxt  = SETTLE_L;
            w_loss_ev_nxt = (r_loss_events == 8'hFF) ? r_loss_events : r_loss_events + 8'd1;
            w_state_nxt   = S_SETTLE;
          end else begin
            w_loss_nxt = r_loss_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_settle_cnt  <= '0;
      r_match_cnt   <= '0;
      r_loss_cnt    <= '0;
      r_tap_phase   <= '0;
      r_slip_cnt    <= '0;
      r_tap_cnt     <= '0;
      r_loss_events <= '0;
      r_id_ld       <= 1'b0;
      r_data_out    <= '0;
    end else begin
      r_settle_cnt  <= w_settle_nxt;
      r_match_cnt   <= w_match_nxt;
      r_loss_cnt    <= w_loss_nxt;
      r_tap_phase   <= w_phase_nxt;
      r_slip_cnt    <= w_slip_nxt;
      r_tap_cnt     <= w_tap_nxt;
      r_loss_events <= w_loss_ev_nxt;
      r_id_ld       <= w_id_ld_nxt;
      if (r_state == S_LOCKED) r_data_out <= data_in;
    end
  end

  assign bitslip     = (r_state == S_SLIP);
  assign id_inc      = (r_state == S_TAP);
  assign id_ld       = r_id_ld;
  assign locked      = (r_state == S_LOCKED);
  assign data_valid  = (r_state == S_LOCKED);
  assign fail        = (r_state == S_FAIL);
  assign data_out    = r_data_out;
  assign slip_count  = r_slip_cnt;
  assign tap_count   = r_tap_cnt;
  assign loss_events = r_loss_events;

endmodule

// File: tb/tb_iserdes_aligner.sv
// Bench for iserdes_aligner: a rotating frame-lane link model with an IDELAY eye
// requirement, checked against closed-form expectations for slips, taps and lock timing.
module tb_iserdes_aligner;
  localparam int N_LANES = 4;
  localparam int DW      = 8;
  localparam int SETTLE  = 8;
  localparam int MATCH   = 16;
  localparam int LOSS    = 4;
  localparam int STEP    = 2;
  localparam logic [7:0] PAT = 8'hF0;
  localparam int ROUND   = (DW - 1) * (SETTLE + 2) + SETTLE + 1 + STEP;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  frame_in = '0;
  logic [31:0] data_in = '0;
  logic        bitslip, id_inc, id_ld, data_valid, locked, fail;
  logic [31:0] data_out;
  logic [2:0]  slip_count;
  logic [4:0]  tap_count;
  logic [7:0]  loss_events;

  iserdes_aligner #(
    .N_LANES(N_LANES), .DW(DW), .FRAME_PATTERN(PAT), .SETTLE_CYCLES(SETTLE),
    .MATCH_COUNT(MATCH), .LOSS_COUNT(LOSS), .TAP_STEP(STEP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .frame_in(frame_in),
    .data_in(data_in), .bitslip(bitslip), .id_inc(id_inc), .id_ld(id_ld),
    .data_out(data_out), .data_valid(data_valid), .locked(locked), .fail(fail),
    .slip_count(slip_count), .tap_count(tap_count), .loss_events(loss_events)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // link model: physical word rotation, IDELAY taps applied, taps needed to open the eye
  int         env_rot = 0;
  int         env_taps = 0;
  int         need_taps = 0;
  bit         force_bad = 1'b0;
  logic [7:0] bad_word = 8'h00;

  int cyc = 0, n_bs = 0, n_inc = 0, n_ld = 0, last_bs = -100;
  int gap_err = 0, excl_err = 0, burst_err = 0, burst_len = 0, slips_since = 0;
  int exp_taps = 0, exp_loss = 0;

  function automatic logic [7:0] rotl(input int k);
    logic [7:0] p;
    p = PAT;
    return 8'((p << k) | (p >> (DW - k)));
  endfunction

  function automatic logic [7:0] env_word();
    if (force_bad || env_taps < need_taps) return bad_word;
    return rotl(env_rot);
  endfunction

  function automatic logic [7:0] pick_bad();
    logic [7:0] w;
    bit is_rot;
    do begin
      w = 8'($urandom);
      is_rot = 1'b0;
      for (int k = 0; k < DW; k++) if (rotl(k) == w) is_rot = 1'b1;
    end while (is_rot);
    return w;
  endfunction

  task automatic tick();
    bit rst_now;
    rst_now = sys_rst;
    @(posedge sys_clk);
    #1;
    cyc++;
    if ((int'(bitslip) + int'(id_inc) + int'(id_ld)) > 1) excl_err++;
    if (rst_now) begin
      burst_len   = 0;
      slips_since = 0;
    end
    if (bitslip) begin
      n_bs++;
      if (cyc - last_bs <= SETTLE) gap_err++;
      last_bs = cyc;
      slips_since++;
      env_rot = (env_rot + DW - 1) % DW;
    end
    if (id_inc) begin
      if (burst_len == 0 && slips_since != DW - 1) burst_err++;
      burst_len++;
      n_inc++;
      env_taps++;
    end else if (burst_len != 0) begin
      if (burst_len != STEP) burst_err++;
      burst_len   = 0;
      slips_since = 0;
    end
    if (id_ld) begin
      n_ld++;
      env_taps    = 0;
      slips_since = 0;
    end
    frame_in = env_word();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bitslip, id_inc, id_ld, data_valid, locked, fail, slip_count, tap_count, loss_events, data_out} !== '0)
      $display("FAIL reset_outputs: got slip=%0d tap=%0d lock=%0d fail=%0d dout=%h, required all zero",
               slip_count, tap_count, locked, fail, data_out);
    else n_pass++;
    sys_rst = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ((n_ld + n_bs + n_inc) !== 0 || locked !== 1'b0)
      $display("FAIL reset_idle: got pulses=%0d locked=%0d, required 0/0", n_ld + n_bs + n_inc, locked);
    else n_pass++;
  endtask

  task automatic test_acquire(input int r, input int rr);
    int t, rp, bs0, inc0, ld0, t_exp;
    env_rot   = r;
    need_taps = STEP * rr;
    force_bad = 1'b0;
    bad_word  = pick_bad();
    rp        = (((r - (DW - 1) * rr) % DW) + DW) % DW;
    t_exp     = rr * ROUND + rp * (SETTLE + 2) + SETTLE + MATCH + 1;
    bs0 = n_bs; inc0 = n_inc; ld0 = n_ld;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 1;
    while (!locked && t < 2000) begin
      tick();
      t++;
    end
    n_checks++;
    if (t !== t_exp) $display("FAIL acq_lock_time r=%0d rr=%0d: got %0d required %0d", r, rr, t, t_exp);
    else n_pass++;
    n_checks++;
    if (slip_count !== 3'(rp)) $display("FAIL acq_slip_count: got %0d required %0d", slip_count, rp);
    else n_pass++;
    n_checks++;
    if (tap_count !== 5'(STEP * rr)) $display("FAIL acq_tap_count: got %0d required %0d", tap_count, STEP * rr);
    else n_pass++;
    n_checks++;
    if (n_bs - bs0 !== (DW - 1) * rr + rp)
      $display("FAIL acq_bitslips: got %0d required %0d", n_bs - bs0, (DW - 1) * rr + rp);
    else n_pass++;
    n_checks++;
    if (n_inc - inc0 !== STEP * rr) $display("FAIL acq_id_inc: got %0d required %0d", n_inc - inc0, STEP * rr);
    else n_pass++;
    n_checks++;
    if (n_ld - ld0 !== 1 || data_valid !== 1'b1 || fail !== 1'b0)
      $display("FAIL acq_ld_valid: got ld=%0d valid=%0d fail=%0d required 1/1/0", n_ld - ld0, data_valid, fail);
    else n_pass++;
    exp_taps = STEP * rr;
  endtask

  task automatic test_loss_and_data();
    logic [31:0] din, held;
    bit bad_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int k;
    bad_word = pick_bad();
    for (int i = 0; i < 10; i++) begin
      din = $urandom;
      data_in = din;
      tick();
      n_checks++;
      if (data_out !== din || data_valid !== 1'b1)
        $display("FAIL data_latency: got %h valid=%0d required %h valid=1", data_out, data_valid, din);
      else n_pass++;
    end
    held = '0;
    for (int i = 0; i < 8; i++) begin
      force_bad = bad_seq[i];
      frame_in  = env_word();
      din       = $urandom;
      data_in   = din;
      held      = din;
      tick();
      n_checks++;
      if (locked !== (i < 7) || data_out !== din)
        $display("FAIL loss_step%0d: got locked=%0d dout=%h required locked=%0d dout=%h",
                 i, locked, data_out, (i < 7), din);
      else n_pass++;
    end
    force_bad = 1'b0;
    frame_in  = env_word();
    exp_loss++;
    n_checks++;
    if (loss_events !== 8'(exp_loss)) $display("FAIL loss_events: got %0d required %0d", loss_events, exp_loss);
    else n_pass++;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      data_in = $urandom;
      tick();
      k++;
      n_checks++;
      if (data_out !== held || data_valid !== 1'b0)
        $display("FAIL data_hold: got %h valid=%0d required %h valid=0", data_out, data_valid, held);
      else n_pass++;
    end
    while (!locked && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== SETTLE + MATCH) $display("FAIL relock_time: got %0d required %0d", k, SETTLE + MATCH);
    else n_pass++;
    n_checks++;
    if (tap_count !== 5'(exp_taps) || slip_count !== 3'd0 || loss_events !== 8'(exp_loss))
      $display("FAIL relock_counts: got tap=%0d slip=%0d loss=%0d required %0d/0/%0d",
               tap_count, slip_count, loss_events, exp_taps, exp_loss);
    else n_pass++;
  endtask

  task automatic test_reset_mid_tap();
    int t, bs0, inc0, ld0;
    need_taps = 99;
    bad_word  = pick_bad();
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 1;
    while (!id_inc && t < 300) begin
      tick();
      t++;
    end
    n_checks++;
    if (id_inc !== 1'b1) $display("FAIL rst_tap_reached: got id_inc=%0d required 1", id_inc);
    else n_pass++;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    exp_loss = 0;
    n_checks++;
    if ({bitslip, id_inc, id_ld, data_valid, locked, fail, slip_count, tap_count, loss_events, data_out} !== '0)
      $display("FAIL rst_mid_tap: got inc=%0d tap=%0d loss=%0d dout=%h, required all zero",
               id_inc, tap_count, loss_events, data_out);
    else n_pass++;
    bs0 = n_bs; inc0 = n_inc; ld0 = n_ld;
    repeat (20) tick();
    n_checks++;
    if ((n_bs - bs0) + (n_inc - inc0) + (n_ld - ld0) !== 0 || slip_count !== 3'd0)
      $display("FAIL rst_stays_idle: got pulses=%0d slip=%0d required 0/0",
               (n_bs - bs0) + (n_inc - inc0) + (n_ld - ld0), slip_count);
    else n_pass++;
  endtask

  task automatic test_exhaust();
    int t, bs0, inc0, ld0, rounds, t_exp;
    need_taps = 99;
    bad_word  = pick_bad();
    rounds = 31 / STEP;
    t_exp  = rounds * ROUND + (DW - 1) * (SETTLE + 2) + SETTLE + 2;
    bs0 = n_bs; inc0 = n_inc; ld0 = n_ld;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 1;
    while (!fail && t < 3000) begin
      tick();
      t++;
    end
    n_checks++;
    if (t !== t_exp) $display("FAIL exh_fail_time: got %0d required %0d", t, t_exp);
    else n_pass++;
    n_checks++;
    if (n_bs - bs0 !== (rounds + 1) * (DW - 1))
      $display("FAIL exh_bitslips: got %0d required %0d", n_bs - bs0, (rounds + 1) * (DW - 1));
    else n_pass++;
    n_checks++;
    if (n_inc - inc0 !== rounds * STEP || n_ld - ld0 !== 1)
      $display("FAIL exh_pulses: got inc=%0d ld=%0d required %0d/1", n_inc - inc0, n_ld - ld0, rounds * STEP);
    else n_pass++;
    n_checks++;
    if (tap_count !== 5'(rounds * STEP) || slip_count !== 3'(DW - 1) || locked !== 1'b0)
      $display("FAIL exh_counts: got tap=%0d slip=%0d locked=%0d required %0d/%0d/0",
               tap_count, slip_count, locked, rounds * STEP, DW - 1);
    else n_pass++;
    bs0 = n_bs; inc0 = n_inc;
    repeat (10) tick();
    n_checks++;
    if (fail !== 1'b1 || (n_bs - bs0) + (n_inc - inc0) !== 0)
      $display("FAIL exh_hold: got fail=%0d pulses=%0d required 1/0", fail, (n_bs - bs0) + (n_inc - inc0));
    else n_pass++;
  endtask

  task automatic test_start_mid_check();
    int t, ld0;
    need_taps = 99;
    bad_word  = pick_bad();
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 1;
    while (slip_count != 3'd5 && t < 300) begin
      tick();
      t++;
    end
    n_checks++;
    if (slip_count !== 3'd5) $display("FAIL smc_reach: got slip=%0d required 5", slip_count);
    else n_pass++;
    repeat (SETTLE) tick();
    ld0 = n_ld;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (id_ld !== 1'b1 || slip_count !== 3'd0 || locked !== 1'b0 || tap_count !== 5'd0)
      $display("FAIL smc_restart: got ld=%0d slip=%0d locked=%0d tap=%0d required 1/0/0/0",
               id_ld, slip_count, locked, tap_count);
    else n_pass++;
    tick();
    t = 2;
    n_checks++;
    if (id_ld !== 1'b0) $display("FAIL smc_ld_single: got id_ld=%0d required 0", id_ld);
    else n_pass++;
    while (!bitslip && t < 100) begin
      tick();
      t++;
    end
    n_checks++;
    if (t !== SETTLE + 2 || n_ld - ld0 !== 1)
      $display("FAIL smc_settle_restart: got slip at %0d ld=%0d required %0d/1", t, n_ld - ld0, SETTLE + 2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_acquire(3, 0);
    for (int i = 0; i < 4; i++) test_acquire(int'($urandom_range(DW - 1, 0)), int'($urandom_range(2, 0)));
    test_loss_and_data();
    test_reset_mid_tap();
    test_exhaust();
    test_start_mid_check();
    n_checks++;
    if (excl_err !== 0) $display("FAIL mutual_exclusion: got %0d overlaps required 0", excl_err);
    else n_pass++;
    n_checks++;
    if (gap_err !== 0) $display("FAIL slip_spacing: got %0d short gaps required 0", gap_err);
    else n_pass++;
    n_checks++;
    if (burst_err !== 0) $display("FAIL tap_bursts: got %0d bad bursts required 0", burst_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
